// File: rtl/regfile_writeback.sv
// Generic synchronous FIFO: registered pointers and count, head data available combinationally.
// Latency: an entry pushed on one edge is visible at the head after that edge.
// Backpressure: full ignores push, empty ignores pop; caller gates with full/empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
            case ({do_push, do_pop})
                2'b10:   cnt <= (AW+1)'(cnt + 1'b1);
                2'b01:   cnt <= (AW+1)'(cnt - 1'b1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Merges ALU results and buffered long-latency results onto one regfile write port; busy scoreboard.
// Latency: ALU 1 cycle, long-latency results 2 cycles minimum (no bypass around the buffer).
// Backpressure: ALU never stalls and preempts the buffer; b_ready_o drops only when the buffer is full.
module regfile_writeback #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          a_valid_i,
    input  logic [4:0]                    a_rd_i,
    input  logic [XLEN-1:0]               a_data_i,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    input  logic [4:0]                    b_rd_i,
    input  logic [XLEN-1:0]               b_data_i,
    input  logic                          issue_valid_i,
    input  logic [4:0]                    issue_rd_i,
    output logic [4:0]                    rd_o,
    output logic [XLEN-1:0]               rd_data_o,
    output logic [31:0]                   busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] dat;
    } wb_t;

    wb_t         push_dat;
    wb_t         head_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic        a_wr;
    logic        b_push;
    logic        b_pop;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_nxt;

    assign b_ready_o = rst_ni & ~fifo_full;
    assign push_dat  = '{rd: b_rd_i, dat: b_data_i};

    always_comb begin
        a_wr     = a_valid_i & (a_rd_i != 5'd0);
        // x0 results are accepted but never enter the buffer.
        b_push   = b_valid_i & b_ready_o & (b_rd_i != 5'd0);
        b_pop    = ~fifo_empty & ~a_wr;
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid_i && issue_rd_i != 5'd0) set_mask[issue_rd_i] = 1'b1;
        if (b_pop) clr_mask[head_dat.rd] = 1'b1;
        // Set applied after clear so a reissue on the drain cycle stays busy.
        busy_nxt    = (busy_o & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    fifo #(
        .W     ($bits(wb_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (b_push),
        .push_dat (push_dat),
        .pop      (b_pop),
        .head_dat (head_dat),
        .cnt      (fifo_cnt_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_o      <= 5'd0;
            rd_data_o <= '0;
            busy_o    <= '0;
        end else begin
            busy_o <= busy_nxt;
            if (a_wr) begin
                rd_o      <= a_rd_i;
                rd_data_o <= a_data_i;
            end else if (b_pop) begin
                rd_o      <= head_dat.rd;
                rd_data_o <= head_dat.dat;
            end else begin
                rd_o      <= 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: inputs driven and outputs sampled 1 time unit after posedge.
module tb_regfile_writeback;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        a_valid_i;
    logic [4:0]  a_rd_i;
    logic [31:0] a_data_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [4:0]  b_rd_i;
    logic [31:0] b_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  rd_o;
    logic [31:0] rd_data_o;
    logic [31:0] busy_o;
    logic [2:0]  fifo_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_writeback #(.XLEN(32), .FIFO_DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .a_valid_i     (a_valid_i),
        .a_rd_i        (a_rd_i),
        .a_data_i      (a_data_i),
        .b_valid_i     (b_valid_i),
        .b_ready_o     (b_ready_o),
        .b_rd_i        (b_rd_i),
        .b_data_i      (b_data_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .rd_o          (rd_o),
        .rd_data_o     (rd_data_o),
        .busy_o        (busy_o),
        .fifo_cnt_o    (fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        a_valid_i     = 1'b0;
        a_rd_i        = 5'd0;
        a_data_i      = 32'd0;
        b_valid_i     = 1'b0;
        b_rd_i        = 5'd0;
        b_data_i      = 32'd0;
        issue_valid_i = 1'b0;
        issue_rd_i    = 5'd0;
    endtask

    task automatic drive_a(input logic [4:0] rd, input logic [31:0] d);
        a_valid_i = 1'b1;
        a_rd_i    = rd;
        a_data_i  = d;
    endtask

    task automatic drive_b(input logic [4:0] rd, input logic [31:0] d);
        b_valid_i = 1'b1;
        b_rd_i    = rd;
        b_data_i  = d;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        #1;
        check("rst_rd",    64'(rd_o),       64'd0);
        check("rst_data",  64'(rd_data_o),  64'd0);
        check("rst_busy",  64'(busy_o),     64'd0);
        check("rst_cnt",   64'(fifo_cnt_o), 64'd0);
        check("rst_ready", 64'(b_ready_o),  64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        check("rel_ready", 64'(b_ready_o), 64'd1);

        // ALU only
        tick();
        drive_a(5'd5, 32'hDEADBEEF);
        tick();
        check("a_rd",   64'(rd_o),      64'd5);
        check("a_data", 64'(rd_data_o), 64'hDEADBEEF);
        idle();
        tick();
        check("a_idle_rd",   64'(rd_o),      64'd0);
        check("a_idle_data", 64'(rd_data_o), 64'hDEADBEEF);
        drive_a(5'd0, 32'h55);
        tick();
        check("a_x0_rd",   64'(rd_o),      64'd0);
        check("a_x0_data", 64'(rd_data_o), 64'hDEADBEEF);
        idle();

        // ALU priority over buffered result
        drive_a(5'd3, 32'h30);
        drive_b(5'd7, 32'h1);
        tick();
        check("pri_rd0",  64'(rd_o),       64'd3);
        check("pri_cnt0", 64'(fifo_cnt_o), 64'd1);
        b_valid_i = 1'b0;
        a_data_i  = 32'h31;
        tick();
        check("pri_rd1",  64'(rd_o),       64'd3);
        check("pri_d1",   64'(rd_data_o),  64'h31);
        check("pri_cnt1", 64'(fifo_cnt_o), 64'd1);
        a_data_i = 32'h32;
        tick();
        check("pri_rd2",  64'(rd_o),       64'd3);
        check("pri_cnt2", 64'(fifo_cnt_o), 64'd1);
        idle();
        tick();
        check("pri_rd3",  64'(rd_o),       64'd7);
        check("pri_d3",   64'(rd_data_o),  64'h1);
        check("pri_cnt3", 64'(fifo_cnt_o), 64'd0);
        tick();
        check("pri_rd4",  64'(rd_o),       64'd0);

        // Full buffer while ALU holds the port
        drive_a(5'd3, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            drive_b(5'(10 + i), 32'h100 + 32'(i));
            check("full_rdy_pre", 64'(b_ready_o), 64'd1);
            tick();
        end
        check("full_cnt4", 64'(fifo_cnt_o), 64'd4);
        check("full_rdy4", 64'(b_ready_o),  64'd0);
        drive_b(5'd14, 32'h104);
        tick();
        check("full_held_cnt", 64'(fifo_cnt_o), 64'd4);
        check("full_held_rd",  64'(rd_o),       64'd3);
        a_valid_i = 1'b0;
        tick();
        check("full_pop_rd",   64'(rd_o),       64'd10);
        check("full_pop_d",    64'(rd_data_o),  64'h100);
        check("full_pop_cnt",  64'(fifo_cnt_o), 64'd3);
        check("full_pop_rdy",  64'(b_ready_o),  64'd1);
        tick();
        check("full_rd11",  64'(rd_o),       64'd11);
        check("full_cnt11", 64'(fifo_cnt_o), 64'd3);
        b_valid_i = 1'b0;
        for (int j = 2; j <= 4; j++) begin
            tick();
            check("full_drain_rd",  64'(rd_o),       64'(10 + j));
            check("full_drain_d",   64'(rd_data_o),  64'(32'h100 + 32'(j)));
            check("full_drain_cnt", 64'(fifo_cnt_o), 64'(4 - j));
        end
        tick();
        check("full_end_rd", 64'(rd_o), 64'd0);

        // Scoreboard
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        tick();
        check("sb_set", 64'(busy_o), 64'h200);
        issue_valid_i = 1'b0;
        drive_b(5'd9, 32'h12);
        tick();
        check("sb_acc_cnt",  64'(fifo_cnt_o), 64'd1);
        check("sb_acc_busy", 64'(busy_o),     64'h200);
        check("sb_acc_rd",   64'(rd_o),       64'd0);
        b_valid_i = 1'b0;
        tick();
        check("sb_wr_rd",   64'(rd_o),      64'd9);
        check("sb_wr_d",    64'(rd_data_o), 64'h12);
        check("sb_clr",     64'(busy_o),    64'd0);
        drive_b(5'd9, 32'h34);
        tick();
        check("sb_re_cnt", 64'(fifo_cnt_o), 64'd1);
        b_valid_i     = 1'b0;
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        tick();
        check("sb_re_rd",   64'(rd_o),   64'd9);
        check("sb_setwins", 64'(busy_o), 64'h200);
        issue_rd_i = 5'd0;
        tick();
        check("sb_x0", 64'(busy_o), 64'h200);
        issue_valid_i = 1'b0;

        // Back-to-back stream wraps the pointers
        for (int i = 0; i < 10; i++) begin
            drive_b(5'(i + 1), 32'h200 + 32'(i));
            tick();
            check("wrap_cnt", 64'(fifo_cnt_o), 64'd1);
            if (i == 0) check("wrap_first", 64'(rd_o), 64'd0);
            else begin
                check("wrap_rd", 64'(rd_o),      64'(i));
                check("wrap_d",  64'(rd_data_o), 64'(32'h200 + 32'(i - 1)));
            end
        end
        b_valid_i = 1'b0;
        tick();
        check("wrap_last_rd",  64'(rd_o),       64'd10);
        check("wrap_last_d",   64'(rd_data_o),  64'h209);
        check("wrap_last_cnt", 64'(fifo_cnt_o), 64'd0);
        check("wrap_busy",     64'(busy_o),     64'd0);

        // Reset in the middle of a burst
        drive_a(5'd3, 32'hC0);
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd20;
        for (int i = 0; i < 3; i++) begin
            drive_b(5'(4 + i), 32'h300 + 32'(i));
            tick();
            issue_valid_i = 1'b0;
        end
        b_valid_i = 1'b0;
        check("mid_cnt",  64'(fifo_cnt_o), 64'd3);
        check("mid_busy", 64'(busy_o),     64'h100000);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rd",    64'(rd_o),       64'd0);
        check("mid_rst_cnt",   64'(fifo_cnt_o), 64'd0);
        check("mid_rst_busy",  64'(busy_o),     64'd0);
        check("mid_rst_ready", 64'(b_ready_o),  64'd0);
        idle();
        tick();
        tick();
        #3;
        rst_ni = 1'b1;
        tick();
        check("mid_rel_ready", 64'(b_ready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("mid_no_stale_rd", 64'(rd_o),       64'd0);
            check("mid_no_stale_cnt", 64'(fifo_cnt_o), 64'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
